// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: packetizer state encoding
// and the default sync byte.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } uart_pkt_state_t;

  localparam logic [7:0] UART_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx_packetizer.sv
// Frames one WORD_BYTES-wide word as: sync byte, data bytes LSB first, and an
// optional XOR checksum byte (enabled by defining UART_TX_CHECKSUM_EN).
module uart_tx_packetizer
  import uart_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = UART_SYNC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_in_valid,
  output logic                    word_in_ready,
  output logic [7:0]              data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic                    busy
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that transfer.

  uart_pkt_state_t         state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [7:0]              byte_sel;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  assign byte_sel       = word_q[{idx_q, 3'b000} +: 8];
  assign word_in_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign data_out_valid = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    data_out = 8'h00;
`ifdef UART_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (word_in_valid) begin
          state_d = HDR;
          word_d  = word_in;
          idx_d   = '0;
`ifdef UART_TX_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      HDR: begin
        data_out = SYNC_BYTE;
        if (data_out_ready) state_d = DATA;
      end
      DATA: begin
        data_out = byte_sel;
        if (data_out_ready) begin
`ifdef UART_TX_CHECKSUM_EN
          csum_d = csum_q ^ byte_sel;
`endif
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_CHECKSUM_EN
      CSUM: begin
        data_out = csum_q;
        if (data_out_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
`ifdef UART_TX_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
`ifdef UART_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed plus randomized bench for uart_tx_packetizer; expected byte stream
// is built from the packet format, matching whichever checksum build is used.
module tb_uart_tx_packetizer;

  localparam int WB = 4;
  localparam int W  = 8 * WB;
`ifdef UART_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] word_in;
  logic         word_in_valid;
  logic         word_in_ready;
  logic [7:0]   data_out;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         busy;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  uart_tx_packetizer #(.WORD_BYTES(WB), .SYNC_BYTE(8'hA5)) dut (
    .clk            (clk),
    .reset          (reset),
    .word_in        (word_in),
    .word_in_valid  (word_in_valid),
    .word_in_ready  (word_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: packet = sync, bytes LSB first, optional XOR of data bytes
  task automatic build_expected(input logic [W-1:0] w);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < WB; i++) begin
      b = 8'((w >> (8 * i)) & 'hFF);
      x = x ^ b;
      exp_q.push_back(b);
    end
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_ready"}, 32'(word_in_ready),  32'd1);
    check({tag, "_data"},  32'(data_out),       32'h00);
  endtask

  // driver: offer a word and wait (bounded) for acceptance
  task automatic offer_word(input logic [W-1:0] w);
    int t;
    bit done;
    word_in = w;
    word_in_valid = 1'b1;
    done = 0;
    t = 0;
    while (!done && t < 50) begin
      if (word_in_ready) done = 1;
      step();
      t++;
    end
    check("accept", 32'(done), 32'd1);
    word_in_valid = 1'b0;
    word_in = W'($urandom);
    build_expected(w);
    check("lat_valid", 32'(data_out_valid), 32'd1);
    check("lat_sync",  32'(data_out),       32'hA5);
  endtask

  // consume bytes; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  // Stops after max_fires byte fires or when the expected queue empties.
  task automatic drain(input int mode, input int max_fires, input bit hold_next,
                       input logic [W-1:0] nw, output int busy_cnt);
    int cyc;
    int fires;
    bit prev_hold;
    logic [7:0] held;
    logic [7:0] e;
    cyc = 0; fires = 0; prev_hold = 0; busy_cnt = 0; held = 8'h00;
    while (exp_q.size() > 0 && fires < max_fires && cyc < 300) begin
      case (mode)
        0: data_out_ready = 1'b1;
        1: data_out_ready = ((cyc % 4) == 0 || (cyc % 4) == 3);
        default: data_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold_next) begin
        word_in = nw;
        word_in_valid = 1'b1;
        check("blocked_ready", 32'(word_in_ready), 32'd0);
      end
      if (busy) busy_cnt++;
      check("out_valid", 32'(data_out_valid), 32'd1);
      if (prev_hold) check("held_byte", 32'(data_out), 32'(held));
      if (data_out_valid && data_out_ready) begin
        e = exp_q.pop_front();
        check("byte", 32'(data_out), 32'(e));
        fires++;
        prev_hold = 0;
      end else begin
        prev_hold = 1;
        held = data_out;
      end
      step();
      cyc++;
    end
    check("drain_timeout", 32'(cyc < 300), 32'd1);
    data_out_ready = 1'b0;
  endtask

  initial begin
    int bc;
    logic [W-1:0] w;
    reset = 1'b1;
    word_in = '0;
    word_in_valid = 1'b0;
    data_out_ready = 1'b0;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post_reset");

    // basic packet, ready held high
    offer_word(32'h12345678);
    drain(0, 100, 1'b0, '0, bc);
    check("busy_cycles", 32'(bc), 32'(WB + 1 + CS));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check_idle("basic_end");

    // backpressure pattern
    offer_word(32'hCAFEF00D);
    drain(1, 100, 1'b0, '0, bc);
    check_idle("bp_end");

    // new word held during an active packet is taken in the first idle cycle
    offer_word(32'h0BADF00D);
    drain(0, 100, 1'b1, 32'hDEADBEEF, bc);
    check_idle("block_idle");
    step();
    word_in_valid = 1'b0;
    build_expected(32'hDEADBEEF);
    check("block_sync", 32'(data_out), 32'hA5);
    drain(2, 100, 1'b0, '0, bc);
    check_idle("block_end");

    // reset after the 2nd data byte fires (sync + 2 data = 3 fires)
    offer_word(32'h11223344);
    drain(0, 3, 1'b0, '0, bc);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check_idle("mid_reset");
    offer_word(32'h55667788);
    drain(0, 100, 1'b0, '0, bc);
    check_idle("after_reset_end");

    // randomized words and ready patterns
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) step();
      offer_word(w);
      drain(2, 100, 1'b0, '0, bc);
      check("rand_empty", 32'(exp_q.size()), 32'd0);
      check_idle("rand_end");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
